// File: rtl/led_blink_scheduler_pkg.sv
// Shared constants for the LED blink scheduler: FSM state encoding and
// the width of a requester index.
package led_blink_scheduler_pkg;

    localparam int REQ_IDX_W = 1;

    // 2-bit FSM encoding.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/led_blink_scheduler_tick_gen.sv
// Timebase prescaler: counts 0..TICK_DIV-1 and pulses tick_o for one cycle
// on the wrap. A synchronous clear holds the count at zero, so the first
// tick after the clear drops arrives TICK_DIV cycles later.
module blink_tick_gen
    import led_blink_scheduler_pkg::*;
#(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = !clr_i && (cnt_q == CW'(TICK_DIV - 1));

    // Next count: hold at zero while cleared, wrap on the tick.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_blink_scheduler.sv
// Two-requester LED blink scheduler. A granted requester gets its LED
// blinked cnt times (ON_TICKS lit, OFF_TICKS dark per blink), then a
// one-cycle done pulse. Ties are broken round-robin.
//
// Handshake: req[i] is a level request held by requester i until it sees
// done with done_id == i (or it withdraws, which aborts without done).
// gnt[i] is the acknowledgement; cnt0/cnt1 are sampled only on the grant
// edge, and nothing on a non-granted line affects an active sequence.
module led_blink_scheduler
    import led_blink_scheduler_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int ON_TICKS  = 250,
    parameter int OFF_TICKS = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [3:0]           cnt0,
    input  logic [3:0]           cnt1,
    output logic [1:0]           gnt,
    output logic                 busy,
    output logic                 done,
    output logic [REQ_IDX_W-1:0] done_id,
    output logic                 ledpin
);

    localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    logic [1:0]           state_q, state_d;
    logic [3:0]           remaining_q, remaining_d;
    logic [PW-1:0]        period_q, period_d;
    logic [REQ_IDX_W-1:0] last_q, last_d;
    logic [REQ_IDX_W-1:0] idx_q, idx_d;
    logic [1:0]           gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [REQ_IDX_W-1:0] done_id_q, done_id_d;
    logic                 led_q, led_d;

    logic                 tick;
    logic                 tick_clr;
    logic [REQ_IDX_W-1:0] grant_sel;
    logic [3:0]           grant_cnt;

    // The prescaler only runs while a blink phase is in progress.
    assign tick_clr = (state_q == S_IDLE) || (state_q == S_DONE);

    blink_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tick_clr),
        .tick_o(tick)
    );

    // Arbitration: single request wins outright, a tie goes to the
    // requester that was not served last.
    assign grant_sel = (req == 2'b01) ? 1'b0 :
                       (req == 2'b10) ? 1'b1 : ~last_q;
    assign grant_cnt = grant_sel ? cnt1 : cnt0;

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign ledpin  = led_q;

    // Scheduler FSM next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        last_d      = last_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        led_d       = led_q;

        case (state_q)
            S_IDLE: begin
                gnt_d  = 2'b00;
                busy_d = 1'b0;
                led_d  = 1'b0;
                if (req != 2'b00) begin
                    idx_d       = grant_sel;
                    last_d      = grant_sel;
                    remaining_d = grant_cnt;
                    period_d    = '0;
                    gnt_d       = grant_sel ? 2'b10 : 2'b01;
                    busy_d      = 1'b1;
                    if (grant_cnt != 4'd0) begin
                        state_d = S_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        done_id_d = grant_sel;
                    end
                end
            end

            S_ON: begin
                if (!req[idx_q]) begin
                    state_d  = S_IDLE;
                    gnt_d    = 2'b00;
                    busy_d   = 1'b0;
                    led_d    = 1'b0;
                    period_d = '0;
                end else if (tick) begin
                    if (period_q == PW'(ON_TICKS - 1)) begin
                        period_d = '0;
                        state_d  = S_OFF;
                        led_d    = 1'b0;
                    end else begin
                        period_d = period_q + PW'(1);
                    end
                end
            end

            S_OFF: begin
                if (!req[idx_q]) begin
                    state_d  = S_IDLE;
                    gnt_d    = 2'b00;
                    busy_d   = 1'b0;
                    led_d    = 1'b0;
                    period_d = '0;
                end else if (tick) begin
                    if (period_q == PW'(OFF_TICKS - 1)) begin
                        period_d    = '0;
                        remaining_d = remaining_q - 4'd1;
                        if (remaining_q == 4'd1) begin
                            state_d   = S_DONE;
                            done_d    = 1'b1;
                            done_id_d = idx_q;
                        end else begin
                            state_d = S_ON;
                            led_d   = 1'b1;
                        end
                    end else begin
                        period_d = period_q + PW'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                led_d   = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                led_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= 4'd0;
            period_q    <= '0;
            last_q      <= 1'b1;
            idx_q       <= '0;
            gnt_q       <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            led_q       <= led_d;
        end
    end

endmodule

// File: doc/led_blink_scheduler.md
LED_BLINK_SCHEDULER -- requirements
Module: led_blink_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per timebase tick (1 ms at 50 MHz); legal range >= 1.
REQ-002 Parameter ON_TICKS, default 250, ticks the LED is lit per blink; legal range >= 1.
REQ-003 Parameter OFF_TICKS, default 250, ticks the LED is dark per blink; legal range >= 1.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port req  input  2  per-requester blink request, level, held until done or abandoned.
REQ-007 Port cnt0  input  4  blink count for requester 0, sampled at grant.
REQ-008 Port cnt1  input  4  blink count for requester 1, sampled at grant.
REQ-009 Port gnt  output  2  one-hot grant; zero when idle.
REQ-010 Port busy  output  1  high while any grant is active.
REQ-011 Port done  output  1  one-cycle pulse at completion of a granted sequence.
REQ-012 Port done_id  output  1  index of the requester finishing; valid only with done.
REQ-013 Port ledpin  output  1  LED drive, high = lit.

Function
REQ-014 FSM states: IDLE, ON, OFF, DONE; all outputs registered.
REQ-015 IDLE: with req != 0, grant one requester at the next edge; only req[0] -> 0; only req[1] -> 1; both -> requester other than last_served.
REQ-016 At grant: latch the requester's count into 4-bit remaining, set gnt, busy=1, clear tick prescaler and period counter, update last_served.
REQ-017 Granted with count != 0 -> ON, ledpin=1 from the same edge as gnt; count == 0 -> DONE directly, ledpin stays 0.
REQ-018 Prescaler counts 0..TICK_DIV-1 and emits one tick per wrap; first tick occurs TICK_DIV cycles after grant.
REQ-019 ON: hold ledpin=1 for exactly ON_TICKS*TICK_DIV cycles, then -> OFF, ledpin=0, period counter and prescaler restart.
REQ-020 OFF: hold ledpin=0 for exactly OFF_TICKS*TICK_DIV cycles, then decrement remaining; remaining now 0 -> DONE, else -> ON.
REQ-021 DONE: one cycle, done=1, done_id=granted index, gnt still asserted, ledpin=0; next edge -> IDLE, gnt=0, busy=0.
REQ-022 Sequence with N blinks, count != 0: gnt high 1 + N*(ON_TICKS+OFF_TICKS)*TICK_DIV cycles (DONE cycle included).
REQ-023 Abort: granted req falls in ON/OFF -> next edge to IDLE, gnt=0, ledpin=0, busy=0, no done pulse; last_served still updated.
REQ-024 req changes on the non-granted line never disturb an active sequence; cnt0/cnt1 changes after grant are ignored.
REQ-025 Requester still high in IDLE after its done is eligible again; round-robin gives the other requester priority if both are high.
REQ-026 No new grant in the DONE cycle; earliest re-grant is the edge leaving IDLE, one cycle after DONE.

Reset
REQ-027 rst_n low at an edge -> state IDLE, gnt=0, busy=0, done=0, done_id=0, ledpin=0, remaining=0, counters=0, last_served=1 (requester 0 wins first tie).
REQ-028 Reset mid-sequence aborts immediately without done; reset dominates all other inputs in that cycle.

Structure
REQ-029 Shared package holds the FSM state encoding (2-bit) and the requester-index width constant.
REQ-030 One sub-module, blink_tick_gen: TICK_DIV prescaler with synchronous clear, emitting a one-cycle tick.

Verification (TICK_DIV=2, ON_TICKS=2, OFF_TICKS=1: 4 cycles on, 2 off)
REQ-031 req=01, cnt0=3 -> gnt=01 next edge, ledpin 4 high/2 low x3, done=1 done_id=0 on cycle 19 after grant, gnt=0 cycle 20.
REQ-032 req=11 from reset, cnt0=cnt1=1, both held -> requester 0 first (7 cycles), IDLE 1 cycle, then requester 1, then requester 0 again.
REQ-033 req=10, cnt1=0 -> gnt=10 one cycle then DONE, done=1 done_id=1, ledpin never high.
REQ-034 req=01, cnt0=5, drop req[0] on cycle 8 -> next edge gnt=0, ledpin=0, no done pulse; pending req[1] granted after one IDLE cycle.
REQ-035 req=01, cnt0=15, rst_n low for 1 cycle during ON -> all outputs at reset values next edge; with req held, new grant one cycle after rst_n releases.
REQ-036 During an active grant, toggle req[1] and cnt0 every cycle -> ledpin waveform and done timing identical to REQ-031.
